// File: rtl/iomem_bridge_pkg.sv
// Shared constants for the byte-stream to iomem bridge.
// Opcodes, status bytes and FSM state encoding.
package iomem_bridge_pkg;

   localparam logic [3:0] OP_READ  = 4'h1;
   localparam logic [3:0] OP_WRITE = 4'h2;

   localparam logic [7:0] ST_OK      = 8'hA5;
   localparam logic [7:0] ST_BADCMD  = 8'hEE;
   localparam logic [7:0] ST_TIMEOUT = 8'hE0;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_BUS  = 3'd3;
   localparam logic [2:0] S_STAT = 3'd4;
   localparam logic [2:0] S_RDAT = 3'd5;

   function automatic logic is_rx_state(input logic [2:0] s);
      return (s == S_IDLE) || (s == S_ADDR) || (s == S_DATA);
   endfunction

endpackage

// File: rtl/le_word_shifter.sv
// 32-bit little-endian word register: byte-lane load,
// full-word load and right shift by one byte.
module le_word_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_ld_byte,
   input  logic [1:0]  i_lane,
   input  logic [7:0]  i_byte,
   input  logic        i_ld_word,
   input  logic [31:0] i_word,
   input  logic        i_shift,
   output logic [31:0] o_word
);

   logic [31:0] r_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
      end else if (i_ld_word) begin
         r_word <= i_word;
      end else if (i_shift) begin
         r_word <= {8'h00, r_word[31:8]};
      end else if (i_ld_byte) begin
         r_word[{i_lane, 3'b000} +: 8] <= i_byte;
      end
   end

   assign o_word = r_word;

endmodule

// File: rtl/iomem_uart_bridge.sv
// Byte-stream command parser acting as picosoc iomem initiator.
// Define IOMEM_TIMEOUT_EN to abort stalled bus cycles with status 0xE0.
module iomem_uart_bridge
   import iomem_bridge_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        iomem_valid,
   input  logic        iomem_ready,
   output logic [3:0]  iomem_wstrb,
   output logic [31:0] iomem_addr,
   output logic [31:0] iomem_wdata,
   input  logic [31:0] iomem_rdata,
   output logic        busy
);

   logic [2:0]  r_state;
   logic [2:0]  w_nstate;
   logic [1:0]  r_cnt;
   logic        r_is_read;
   logic        r_bad;
   logic [3:0]  r_wstrb;
   logic        r_rx_ready;
   logic        r_tx_valid;
   logic [7:0]  r_tx_data;
   logic        r_iomem_valid;
   logic        w_rx_fire;
   logic        w_tx_fire;
   logic        w_op_read;
   logic        w_op_write;
   logic        w_tmo;
   logic [31:0] w_addr;
   logic [31:0] w_word;

   assign w_rx_fire  = rx_valid & r_rx_ready;
   assign w_tx_fire  = r_tx_valid & tx_ready;
   assign w_op_read  = (rx_data == {OP_READ, 4'h0});
   assign w_op_write = (rx_data[7:4] == OP_WRITE);

`ifdef IOMEM_TIMEOUT_EN
   logic [15:0] r_tmo;

   // ready in the expiry cycle wins, hence the !iomem_ready term
   assign w_tmo = (r_state == S_BUS) && !iomem_ready &&
                  (r_tmo == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= (r_state == S_BUS) ? r_tmo + 16'd1 : '0;
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_nstate = r_state;
      unique case (r_state)
         S_IDLE:
            if (w_rx_fire)
               w_nstate = (w_op_read || w_op_write) ? S_ADDR : S_STAT;
         S_ADDR:
            if (w_rx_fire && r_cnt == 2'd3)
               w_nstate = r_is_read ? S_BUS : S_DATA;
         S_DATA:
            if (w_rx_fire && r_cnt == 2'd3)
               w_nstate = r_bad ? S_STAT : S_BUS;
         S_BUS:
            if (iomem_ready || w_tmo)
               w_nstate = S_STAT;
         S_STAT:
            if (w_tx_fire)
               w_nstate = r_is_read ? S_RDAT : S_IDLE;
         S_RDAT:
            if (w_tx_fire && r_cnt == 2'd3)
               w_nstate = S_IDLE;
         default:
            w_nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_is_read     <= 1'b0;
         r_bad         <= 1'b0;
         r_wstrb       <= '0;
         r_rx_ready    <= 1'b0;
         r_tx_valid    <= 1'b0;
         r_tx_data     <= '0;
         r_iomem_valid <= 1'b0;
      end else begin
         r_state       <= w_nstate;
         r_rx_ready    <= is_rx_state(w_nstate);
         r_iomem_valid <= (w_nstate == S_BUS);
         if (w_nstate != r_state)
            r_cnt <= '0;
         else if (w_rx_fire || (r_state == S_RDAT && w_tx_fire))
            r_cnt <= r_cnt + 2'd1;
         if (r_state == S_IDLE && w_rx_fire) begin
            r_is_read <= w_op_read;
            r_bad     <= (rx_data[3:0] == 4'h0);
            r_wstrb   <= w_op_write ? rx_data[3:0] : 4'h0;
         end
         if (w_tmo)
            r_is_read <= 1'b0;
         if (w_nstate == S_STAT && r_state != S_STAT) begin
            r_tx_valid <= 1'b1;
            if (r_state == S_BUS)
               r_tx_data <= iomem_ready ? ST_OK : ST_TIMEOUT;
            else
               r_tx_data <= ST_BADCMD;
         end else if (w_tx_fire) begin
            // word[7:0] is D0 until the first RDAT shift
            if (w_nstate == S_RDAT && r_state == S_STAT)
               r_tx_data <= w_word[7:0];
            else if (w_nstate == S_RDAT)
               r_tx_data <= w_word[15:8];
            else
               r_tx_valid <= 1'b0;
         end
      end
   end

   le_word_shifter u_addr (
      .clk       (clk),
      .rst_n     (resetn),
      .i_ld_byte (w_rx_fire && r_state == S_ADDR),
      .i_lane    (r_cnt),
      .i_byte    (rx_data),
      .i_ld_word (1'b0),
      .i_word    (32'h0),
      .i_shift   (1'b0),
      .o_word    (w_addr)
   );

   le_word_shifter u_data (
      .clk       (clk),
      .rst_n     (resetn),
      .i_ld_byte (w_rx_fire && r_state == S_DATA),
      .i_lane    (r_cnt),
      .i_byte    (rx_data),
      .i_ld_word (r_state == S_BUS && iomem_ready && r_is_read),
      .i_word    (iomem_rdata),
      .i_shift   (r_state == S_RDAT && w_tx_fire),
      .o_word    (w_word)
   );

   assign rx_ready    = r_rx_ready;
   assign tx_valid    = r_tx_valid;
   assign tx_data     = r_tx_data;
   assign iomem_valid = r_iomem_valid;
   assign iomem_wstrb = r_wstrb;
   assign iomem_addr  = w_addr;
   assign iomem_wdata = w_word;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_iomem_uart_bridge.sv
// Self-checking bench for iomem_uart_bridge: packet-level model,
// iomem responder with wait states, tx back-pressure and reset.
module tb_iomem_uart_bridge;

   localparam int TMO = 8;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        iomem_valid;
   logic        iomem_ready = 1'b0;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata = 32'h0;
   logic        busy;

   iomem_uart_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .iomem_valid (iomem_valid),
      .iomem_ready (iomem_ready),
      .iomem_wstrb (iomem_wstrb),
      .iomem_addr  (iomem_addr),
      .iomem_wdata (iomem_wdata),
      .iomem_rdata (iomem_rdata),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      if (a == 32'h10) return 32'h12345678;
      return {a[15:0], ~a[15:0]};
   endfunction

   always @(posedge clk) cyc++;

   // iomem responder: ready after dly valid cycles; dly<0 never
   int dly = 0;
   int vcnt = 0;
   int rises = 0;
   int txns = 0;
   int last_vc = 0;
   int rise_cyc = 0;
   int rdy_cyc = 0;
   logic [31:0] c_addr = 0;
   logic [31:0] c_wdata = 0;
   logic [3:0]  c_wstrb = 0;

   always @(negedge clk) begin
      if (iomem_valid) begin
         if (vcnt == 0) begin
            c_addr = iomem_addr;
            c_wdata = iomem_wdata;
            c_wstrb = iomem_wstrb;
            rises++;
            rise_cyc = cyc;
         end else begin
            chk("hold_addr", iomem_addr, c_addr);
            chk("hold_wstrb", {28'h0, iomem_wstrb}, {28'h0, c_wstrb});
            chk("hold_wdata", iomem_wdata, c_wdata);
         end
         chk("rx_ready_in_bus", {31'h0, rx_ready}, 32'h0);
         if (dly >= 0 && vcnt >= dly) begin
            iomem_ready = 1'b1;
            iomem_rdata = rd_model(iomem_addr);
            txns++;
            rdy_cyc = cyc;
         end else begin
            iomem_ready = 1'b0;
            iomem_rdata = 32'h0BAD0BAD;
         end
         vcnt++;
      end else begin
         if (vcnt > 0) last_vc = vcnt;
         vcnt = 0;
         iomem_ready = 1'b0;
      end
   end

   // tx sink with optional 3-low/1-high back-pressure
   bit stall = 0;
   int sc = 0;
   always @(negedge clk) begin
      sc++;
      tx_ready = stall ? (sc % 4 == 3) : 1'b1;
   end

   int txrise_cyc = -1;
   logic txv_prev = 1'b0;
   always @(negedge clk) begin
      if (tx_valid && !txv_prev) txrise_cyc = cyc;
      txv_prev = tx_valid;
   end

   logic [7:0] got[$];
   logic       hold = 1'b0;
   logic [7:0] hold_d = 8'h00;
   always @(posedge clk) begin
      if (resetn) begin
         if (hold) begin
            chk("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
            chk("tx_hold_data", {24'h0, tx_data}, {24'h0, hold_d});
         end
         if (tx_valid)
            chk("rx_ready_in_tx", {31'h0, rx_ready}, 32'h0);
         if (tx_valid && tx_ready) got.push_back(tx_data);
         hold = tx_valid && !tx_ready;
         hold_d = tx_data;
      end else begin
         hold = 1'b0;
      end
   end

   int last_acc = 0;

   task automatic send(input bq_t b);
      int k;
      foreach (b[i]) begin
         rx_data = b[i];
         rx_valid = 1'b1;
         k = 0;
         while (!rx_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
         end
         if (!rx_ready) begin
            chk("rx_accept_timeout", 32'h0, 32'h1);
            break;
         end
         @(posedge clk); #1;
         last_acc = cyc;
      end
      rx_valid = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic run(input string nm, input bq_t pk, input int d,
                      input bit st);
      bq_t exp;
      bit bus;
      logic [7:0] op;
      logic [31:0] a, w, rd;
      logic [3:0] s;
      int exp_vc, r0, t0, k;
      op = pk[0];
      bus = 0;
      s = 0;
      a = 0;
      w = 0;
      exp_vc = 0;
      exp = {};
      if (pk.size() >= 5) a = {pk[4], pk[3], pk[2], pk[1]};
      if (pk.size() >= 9) w = {pk[8], pk[7], pk[6], pk[5]};
      if (op == 8'h10) begin
         bus = 1;
      end else if (op[7:4] == 4'h2) begin
         if (op[3:0] == 4'h0) exp = {8'hEE};
         else begin
            bus = 1;
            s = op[3:0];
         end
      end else begin
         exp = {8'hEE};
      end
      if (bus) begin
         if (d < 0) begin
            exp = {8'hE0};
            exp_vc = TMO;
         end else begin
            exp = {8'hA5};
            exp_vc = d + 1;
            if (s == 0) begin
               rd = rd_model(a);
               exp.push_back(rd[7:0]);
               exp.push_back(rd[15:8]);
               exp.push_back(rd[23:16]);
               exp.push_back(rd[31:24]);
            end
         end
      end
      dly = d;
      stall = st;
      got.delete();
      r0 = rises;
      t0 = txns;
      txrise_cyc = -1;
      send(pk);
      k = 0;
      while ((got.size() < exp.size() || busy) && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_len"}, got.size(), exp.size());
      foreach (exp[i])
         chk($sformatf("%s_b%0d", nm, i),
             (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD,
             {24'h0, exp[i]});
      chk({nm, "_rises"}, rises - r0, bus ? 1 : 0);
      if (bus) begin
         chk({nm, "_addr"}, c_addr, a);
         chk({nm, "_wstrb"}, {28'h0, c_wstrb}, {28'h0, s});
         if (s != 0) chk({nm, "_wdata"}, c_wdata, w);
         chk({nm, "_vcycles"}, last_vc, exp_vc);
         chk({nm, "_vlat"}, rise_cyc, last_acc);
         chk({nm, "_txns"}, txns - t0, (d >= 0) ? 1 : 0);
         if (d >= 0) chk({nm, "_slat"}, txrise_cyc, rdy_cyc + 1);
      end else begin
         chk({nm, "_elat"}, txrise_cyc, last_acc);
      end
      stall = 0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_rx_ready"}, {31'h0, rx_ready}, 32'h0);
      chk({nm, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
      chk({nm, "_tx_data"}, {24'h0, tx_data}, 32'h0);
      chk({nm, "_busy"}, {31'h0, busy}, 32'h0);
      chk({nm, "_valid"}, {31'h0, iomem_valid}, 32'h0);
      chk({nm, "_wstrb"}, {28'h0, iomem_wstrb}, 32'h0);
      chk({nm, "_addr"}, iomem_addr, 32'h0);
      chk({nm, "_wdata"}, iomem_wdata, 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t p;
      #1;
      chk_zero("reset");
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      chk("idle_rx_ready", {31'h0, rx_ready}, 32'h1);

      p = {8'h10, 8'h10, 8'h00, 8'h00, 8'h00};
      run("t1_read", p, 0, 0);
      chk("t1_lit0", {24'h0, got[0]}, 32'hA5);
      chk("t1_lit1", {24'h0, got[1]}, 32'h78);
      chk("t1_lit2", {24'h0, got[2]}, 32'h56);
      chk("t1_lit3", {24'h0, got[3]}, 32'h34);
      chk("t1_lit4", {24'h0, got[4]}, 32'h12);
      chk("t1_lit_addr", c_addr, 32'h10);
      chk("t1_lit_vc", last_vc, 1);

      p = {8'h2F, 8'h20, 8'h00, 8'h00, 8'h00,
           8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run("t2_write", p, 0, 0);
      chk("t2_lit_wdata", c_wdata, 32'hDEADBEEF);
      chk("t2_lit_wstrb", {28'h0, c_wstrb}, 32'hF);
      chk("t2_lit_addr", c_addr, 32'h20);

      p = {8'h10, 8'h10, 8'h00, 8'h00, 8'h00};
      run("t3_wait_read", p, 5, 1);
      p = {8'h23, 8'h44, 8'h33, 8'h22, 8'h11,
           8'h01, 8'h02, 8'h03, 8'h04};
      run("t3_wait_write", p, 2, 1);
      p = {8'h10, 8'h34, 8'h12, 8'h00, 8'h80};
      run("t3_read_hi", p, 1, 0);

      p = {8'h33};
      run("t4_badop", p, 0, 0);
      p = {8'hA5};
      run("t4_a5op", p, 0, 0);
      p = {8'h20, 8'h20, 8'h00, 8'h00, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44};
      run("t4_s0", p, 0, 0);
      p = {8'h10, 8'h10, 8'h00, 8'h00, 8'h00};
      run("t4_after", p, 0, 0);

`ifdef IOMEM_TIMEOUT_EN
      p = {8'h10, 8'h30, 8'h00, 8'h00, 8'h00};
      run("t5_tmo", p, -1, 0);
      run("t5_next", p, 0, 0);
`endif

      p = {8'h10, 8'h40, 8'h00};
      send(p);
      chk("t6_busy_pre", {31'h0, busy}, 32'h1);
      resetn = 1'b0;
      #1;
      chk_zero("t6_rst");
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      p = {8'h10, 8'h50, 8'h00, 8'h00, 8'h00};
      run("t6_fresh", p, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
